// File: rtl/cordic_phase_gen.sv
// Phase-angle sequencer for the cordic pipeline: emits start_phase + n*step wrapped into [-PI, +PI].
// Optional backpressure counter enabled by defining CORDIC_PHASE_GEN_STALL_CNT_EN.
module cordic_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int CNT_W   = 16,
  parameter int PI_Q    = 51472
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [PHASE_W-1:0] start_phase,
  input  logic [PHASE_W-1:0] step,
  input  logic [CNT_W-1:0]   count,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               theta_wr_en,
  output logic [PHASE_W-1:0] theta_din,
  input  logic               theta_full,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic signed [PHASE_W-1:0] PI_S     = PHASE_W'(PI_Q);
  localparam logic signed [PHASE_W-1:0] NEG_PI_S = -PHASE_W'(PI_Q);
  localparam logic signed [PHASE_W-1:0] TWO_PI_S = PHASE_W'(2 * PI_Q);

  logic [1:0]                state_r;
  logic [1:0]                state_nxt_s;
  logic signed [PHASE_W-1:0] phase_r;
  logic signed [PHASE_W-1:0] step_r;
  logic signed [PHASE_W-1:0] sum_s;
  logic signed [PHASE_W-1:0] next_phase_s;
  logic signed [PHASE_W-1:0] start_phase_s;
  logic signed [PHASE_W-1:0] step_in_s;
  logic [CNT_W-1:0]          remaining_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      err_r;
  logic                      range_ok_s;
  logic                      accept_s;
  logic                      write_s;

  assign start_phase_s = $signed(start_phase);
  assign step_in_s     = $signed(step);
  assign range_ok_s    = (start_phase_s <= PI_S) && (start_phase_s >= NEG_PI_S) &&
                         (step_in_s <= PI_S) && (step_in_s >= NEG_PI_S);
  assign accept_s      = (state_r == IDLE) && start && range_ok_s;
  // abort wins over a write in the same cycle
  assign write_s       = (state_r == RUN) && !theta_full && !abort;

  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;
  assign theta_wr_en = write_s;
  assign theta_din   = phase_r;

  // Next-state decode for the IDLE/RUN/FIN sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = (count == {CNT_W{1'b0}}) ? FIN : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt_s = FIN;
        end else if (write_s && (remaining_r == CNT_W'(1))) begin
          state_nxt_s = FIN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Wrap the advanced phase back into [-PI, +PI]; both operands are in range so one correction suffices
  always_comb begin
    sum_s = phase_r + step_r;
    if (sum_s > PI_S) begin
      next_phase_s = sum_s - TWO_PI_S;
    end else if (sum_s < NEG_PI_S) begin
      next_phase_s = sum_s + TWO_PI_S;
    end else begin
      next_phase_s = sum_s;
    end
  end

  // State, status flags and phase/step/remaining registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      phase_r     <= {PHASE_W{1'b0}};
      step_r      <= {PHASE_W{1'b0}};
      remaining_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == FIN);
      err_r   <= (state_r == IDLE) && start && !range_ok_s;
      if (accept_s) begin
        phase_r     <= start_phase_s;
        step_r      <= step_in_s;
        remaining_r <= count;
      end else if (write_s) begin
        phase_r     <= next_phase_s;
        remaining_r <= remaining_r - CNT_W'(1);
      end else begin
        phase_r     <= phase_r;
        remaining_r <= remaining_r;
      end
    end
  end

`ifdef CORDIC_PHASE_GEN_STALL_CNT_EN
  logic [CNT_W-1:0] stall_r;

  assign stall_cnt = stall_r;

  // Saturating count of RUN cycles spent blocked by a full FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      stall_r <= {CNT_W{1'b0}};
    end else if ((state_r == RUN) && theta_full && (stall_r != {CNT_W{1'b1}})) begin
      stall_r <= stall_r + CNT_W'(1);
    end else begin
      stall_r <= stall_r;
    end
  end
`else
  assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
